// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width, FSM state encoding and the derived datapath widths.
package seq_divider_pkg;

    // Default operand width; dividend is twice this wide.
    localparam int unsigned BwDefault = 16;

    // Derived widths at the default operand width.
    localparam int unsigned DvdWDefault = 2 * BwDefault;
    localparam int unsigned RemWDefault = BwDefault + 1;

    // Controller states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Dividend width for a given operand width.
    function automatic int unsigned dvd_width(input int unsigned bw);
        return 2 * bw;
    endfunction

    // Partial remainder width: one guard bit above the operand width.
    function automatic int unsigned rem_width(input int unsigned bw);
        return bw + 1;
    endfunction

    // Iteration counter width, wide enough to hold bw-1 for any bw >= 1.
    function automatic int unsigned cnt_width(input int unsigned bw);
        return (bw < 2) ? 1 : $clog2(bw);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider. The requester drives
// start and the operands; the divider returns status and results.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int unsigned bw = BwDefault
) ();

    logic            start;
    logic [2*bw-1:0] dividend;
    logic [bw-1:0]   divisor;
    logic            busy;
    logic            done;
    logic [bw-1:0]   quotient;
    logic [bw-1:0]   remainder;
    logic            div_by_zero;
    logic            overflow;

    // Requester side.
    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero,
        input  overflow
    );

    // Divider side.
    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero,
        output overflow
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, emit the quotient bit.
module seq_divider_div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned bw = BwDefault
) (
    input  logic [bw:0]   r_i,
    input  logic          bit_i,
    input  logic [bw-1:0] divisor_i,
    output logic [bw:0]   r_o,
    output logic          q_o
);

    logic [bw:0] trial;
    logic [bw:0] dvs_ext;

    // R < divisor on entry, so its top bit is always zero and drops out of T.
    logic unused_r_msb;
    assign unused_r_msb = r_i[bw];

    // Trial subtraction at bw+1 bits; restore by keeping T when it does not fit.
    always_comb begin
        trial   = {r_i[bw-1:0], bit_i};
        dvs_ext = {1'b0, divisor_i};
        r_o     = trial;
        q_o     = 1'b0;
        if (trial >= dvs_ext) begin
            r_o = trial - dvs_ext;
            q_o = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2*bw-bit dividend by bw-bit divisor, one
// quotient bit per clock, with start/busy/done handshake. Divide-by-zero and
// quotient overflow are detected at acceptance and finish in one cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned bw = BwDefault
) (
    input logic          CLK,
    input logic          RESETn,
    seq_divider_if.slave bus
);

    localparam int unsigned CntW = cnt_width(bw);
    localparam int unsigned RemW = rem_width(bw);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RemW-1:0] rem_q, rem_d;          // partial remainder R
    logic [bw-1:0]   lo_q, lo_d;            // unconsumed low dividend bits, MSB next
    logic [bw-1:0]   dvs_q, dvs_d;          // latched divisor
    logic [bw-1:0]   quo_q, quo_d;          // quotient bits collected so far
    logic [bw-1:0]   quotient_q, quotient_d;
    logic [bw-1:0]   remainder_q, remainder_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;

    logic [RemW-1:0] step_r;
    logic            step_q;
    logic [bw-1:0]   dvd_hi;
    logic [bw-1:0]   dvd_lo;
    logic [bw-1:0]   quo_next;

    assign dvd_hi   = bus.dividend[2*bw-1:bw];
    assign dvd_lo   = bus.dividend[bw-1:0];
    assign quo_next = (quo_q << 1) | bw'(step_q);

    seq_divider_div_step #(
        .bw (bw)
    ) u_step (
        .r_i       (rem_q),
        .bit_i     (lo_q[bw-1]),
        .divisor_i (dvs_q),
        .r_o       (step_r),
        .q_o       (step_q)
    );

    // Next-state logic: acceptance and error routing in idle, one iteration per RUN cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        dvs_d       = dvs_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dvs_d = bus.divisor;
                    lo_d  = dvd_lo;
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (bus.divisor == '0) begin
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dvd_lo;
                        state_d     = StDone;
                    end else if (dvd_hi >= bus.divisor) begin
                        // Quotient would need more than bw bits.
                        ovf_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '0;
                        state_d     = StDone;
                    end else begin
                        rem_d   = {1'b0, dvd_hi};
                        cnt_d   = '0;
                        quo_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                rem_d = step_r;
                lo_d  = lo_q << 1;
                quo_d = quo_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(bw - 1)) begin
                    quotient_d  = quo_next;
                    remainder_d = step_r[bw-1:0];
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset aborts any operation.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            lo_q        <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            dvs_q       <= dvs_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // Status decodes straight from the state register; results from output registers.
    always_comb begin
        bus.busy        = (state_q != StIdle);
        bus.done        = (state_q == StDone);
        bus.quotient    = quotient_q;
        bus.remainder   = remainder_q;
        bus.div_by_zero = dbz_q;
        bus.overflow    = ovf_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset values, normal and boundary divides,
// error routing, handshake masking, asynchronous abort and a round trip
// against products computed here.
module tb_seq_divider;

    localparam int unsigned Bw = 16;

    logic clk;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;
    int   lat;
    int   busy_cnt;

    seq_divider_if #(.bw(Bw)) bus ();

    seq_divider #(
        .bw (Bw)
    ) dut (
        .CLK    (clk),
        .RESETn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge, then scramble the inputs.
    task automatic start_op(input logic [31:0] dvd, input logic [15:0] dvs);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        tick();
        bus.start    = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 16'h0000;
    endtask

    // Count cycles from the accepting edge until done, bounded.
    task automatic wait_done(input int max_cycles);
        lat      = 1;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < max_cycles) begin
            tick();
            lat++;
            busy_cnt += bus.busy ? 1 : 0;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                                input logic dbz, input logic ovf);
        check({tag, "_quo"}, 32'(bus.quotient), 32'(q));
        check({tag, "_rem"}, 32'(bus.remainder), 32'(r));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(dbz));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check_result("rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        #10;
        rst_n = 1'b1;
        tick();

        // Basic 100 / 7.
        start_op(32'h0000_0064, 16'h0007);
        wait_done(40);
        check("basic_lat", 32'(lat), 32'd17);
        check("basic_busy_cycles", 32'(busy_cnt), 32'd17);
        check_result("basic", 16'h000E, 16'h0002, 1'b0, 1'b0);
        tick();
        check("basic_done_pulse", 32'(bus.done), 32'd0);
        check("basic_idle_busy", 32'(bus.busy), 32'd0);
        check_result("basic_hold", 16'h000E, 16'h0002, 1'b0, 1'b0);

        // Divide by zero.
        start_op(32'h1234_5678, 16'h0000);
        wait_done(40);
        check("dbz_lat", 32'(lat), 32'd1);
        check_result("dbz", 16'hFFFF, 16'h5678, 1'b1, 1'b0);
        tick();

        // Quotient overflow: high half equals divisor.
        start_op(32'h0001_0000, 16'h0001);
        wait_done(40);
        check("ovf_lat", 32'(lat), 32'd1);
        check_result("ovf", 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        tick();

        // Largest non-overflowing operands; also clears the previous flag.
        start_op(32'hFFFE_0001, 16'hFFFF);
        wait_done(40);
        check("max_lat", 32'(lat), 32'd17);
        check_result("max", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        tick();

        // Start pulses at cycle 5 and in the DONE cycle must be ignored.
        start_op(32'd1000, 16'd9);
        for (int cyc = 1; cyc < 17; cyc++) begin
            bus.start    = (cyc == 5);
            bus.dividend = 32'd2000;
            bus.divisor  = 16'd3;
            tick();
        end
        check("hs_done17", 32'(bus.done), 32'd1);
        check_result("hs_first", 16'd111, 16'd1, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("hs_idle_busy", 32'(bus.busy), 32'd0);
        check_result("hs_hold", 16'd111, 16'd1, 1'b0, 1'b0);
        start_op(32'd2000, 16'd3);
        check("hs_accept_busy", 32'(bus.busy), 32'd1);
        wait_done(40);
        check("hs_second_lat", 32'(lat), 32'd17);
        check_result("hs_second", 16'd666, 16'd2, 1'b0, 1'b0);
        tick();

        // Asynchronous abort in the middle of RUN.
        start_op(32'h0000_0064, 16'h0007);
        for (int cyc = 1; cyc < 8; cyc++) tick();
        check("abort_pre_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check_result("abort", 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("abort_no_done", 32'(bus.done), 32'd0);
        start_op(32'h0000_0064, 16'h0007);
        wait_done(40);
        check("post_abort_lat", 32'(lat), 32'd17);
        check_result("post_abort", 16'h000E, 16'h0002, 1'b0, 1'b0);
        tick();

        // Round trip against a*b products.
        a = 32'd1;
        b = 32'd2;
        for (int i = 0; i < 200; i++) begin
            start_op(a * b, b[15:0]);
            wait_done(40);
            check_result("roundtrip", a[15:0], 16'h0000, 1'b0, 1'b0);
            tick();
            a = a + 32'd1;
            b = b + 32'd2;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
